// File: rtl/bus_master_arbiter.sv
// Round-robin owner arbiter for four active-low bus masters; grants are registered, 1 clock from request.
// Owner keeps the bus while its request stays low; optional BUS_ARB_TIMEOUT_EN adds a forced revoke after MAX_HOLD.
module bus_master_arbiter #(
    parameter int MAX_HOLD = 255,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_,
    output logic [3:0] grnt_,
    output logic [1:0] owner,
    output logic       bus_idle,
    output logic       timeout,
    output logic [1:0] timeout_id
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t     state;
    logic [1:0] last;
    logic [3:0] cand;
    logic [1:0] base;
    logic [1:0] sel;
    logic       sel_vld;

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
        $error("bus_master_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       mask;

    assign cand = ~req_ & ~mask;
`else
    assign cand       = ~req_;
    assign timeout    = 1'b0;
    assign timeout_id = 2'd0;
`endif

    // On release the owner becomes the new round-robin reference, so scan from it directly.
    assign base = (state == OWNED) ? owner : last;

    always_comb begin
        logic [1:0] idx;
        sel_vld = 1'b0;
        sel     = base;
        idx     = base;
        // Descending scan: the nearest requester after base is written last and wins.
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (cand[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grnt_    <= 4'b1111;
            owner    <= 2'd0;
            bus_idle <= 1'b1;
            last     <= 2'd3;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout    <= 1'b0;
            timeout_id <= 2'd0;
            hold_cnt   <= '0;
            mask       <= 4'b0000;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            timeout <= 1'b0;
            mask    <= mask & ~req_;
`endif
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        grnt_    <= ~(4'b0001 << sel);
                        owner    <= sel;
                        bus_idle <= 1'b0;
                        state    <= OWNED;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (req_[owner]) begin
                        last <= owner;
                        if (sel_vld) begin
                            grnt_ <= ~(4'b0001 << sel);
                            owner <= sel;
`ifdef BUS_ARB_TIMEOUT_EN
                            hold_cnt <= '0;
`endif
                        end else begin
                            grnt_    <= 4'b1111;
                            bus_idle <= 1'b1;
                            state    <= IDLE;
                        end
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                        grnt_      <= 4'b1111;
                        bus_idle   <= 1'b1;
                        timeout    <= 1'b1;
                        timeout_id <= owner;
                        last       <= owner;
                        mask       <= (mask & ~req_) | (4'b0001 << owner);
                        state      <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: reset, single grant, round-robin order, handoff, mid-transaction reset, hold limit.
module tb_bus_master_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_;
    logic [3:0] grnt_;
    logic [1:0] owner;
    logic       bus_idle;
    logic       timeout;
    logic [1:0] timeout_id;

    int errors = 0;
    int checks = 0;

    bus_master_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_       (req_),
        .grnt_      (grnt_),
        .owner      (owner),
        .bus_idle   (bus_idle),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_  = 4'b1111;
        tick();
        tick();
        checks++;
        if (grnt_ !== 4'b1111) begin errors++; $display("FAIL reset_grnt: got %b want 1111", grnt_); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
        checks++;
        if (bus_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", bus_idle); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++;
        if (timeout_id !== 2'd0) begin errors++; $display("FAIL reset_timeout_id: got %0d want 0", timeout_id); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        req_ = 4'b1110;
        tick();
        checks++;
        if (grnt_ !== 4'b1110) begin errors++; $display("FAIL single_grant: got %b want 1110", grnt_); end
        checks++;
        if (owner !== 2'd0) begin errors++; $display("FAIL single_owner: got %0d want 0", owner); end
        checks++;
        if (bus_idle !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus_idle); end
        req_ = 4'b1111;
        tick();
        checks++;
        if (grnt_ !== 4'b1111) begin errors++; $display("FAIL single_release: got %b want 1111", grnt_); end
        checks++;
        if (bus_idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", bus_idle); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        reset = 1'b1;
        req_  = 4'b1111;
        tick();
        reset = 1'b0;
        req_  = 4'b0000;
        tick();
        for (int m = 0; m < 4; m++) begin
            exp = 4'b1111;
            exp[m] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (grnt_ !== exp) begin
                    errors++;
                    $display("FAIL rr_grant m%0d c%0d: got %b want %b", m, c, grnt_, exp);
                end
                if (c != 2) tick();
            end
            checks++;
            if (owner !== 2'(m)) begin errors++; $display("FAIL rr_owner m%0d: got %0d want %0d", m, owner, m); end
            req_[m] = 1'b1;
            tick();
        end
        checks++;
        if (grnt_ !== 4'b1111 || bus_idle !== 1'b1) begin
            errors++;
            $display("FAIL rr_end: grnt %b idle %b want 1111 1", grnt_, bus_idle);
        end
    endtask

    task automatic test_handoff_order();
        // last is 3 here: master 1 alone, then 0 and 3 join; release of 1 must pick 3 first.
        req_ = 4'b1101;
        tick();
        checks++;
        if (grnt_ !== 4'b1101) begin errors++; $display("FAIL ho_m1: got %b want 1101", grnt_); end
        req_ = 4'b0100;
        tick();
        checks++;
        if (grnt_ !== 4'b1101) begin errors++; $display("FAIL ho_hold: got %b want 1101", grnt_); end
        req_ = 4'b0110;
        tick();
        checks++;
        if (grnt_ !== 4'b0111 || owner !== 2'd3) begin
            errors++;
            $display("FAIL ho_m3: grnt %b owner %0d want 0111 3", grnt_, owner);
        end
        req_ = 4'b1110;
        tick();
        checks++;
        if (grnt_ !== 4'b1110) begin errors++; $display("FAIL ho_m0: got %b want 1110", grnt_); end
        req_ = 4'b1111;
        tick();
        checks++;
        if (grnt_ !== 4'b1111 || owner !== 2'd0 || bus_idle !== 1'b1) begin
            errors++;
            $display("FAIL ho_idle: grnt %b owner %0d idle %b want 1111 0 1", grnt_, owner, bus_idle);
        end
    endtask

    task automatic test_back_to_back();
        // last is 0: master 1 hands to 2, then re-requests and must queue behind 3.
        req_ = 4'b1101;
        tick();
        checks++;
        if (grnt_ !== 4'b1101) begin errors++; $display("FAIL b2b_m1: got %b want 1101", grnt_); end
        req_ = 4'b1001;
        tick();
        req_ = 4'b1011;
        tick();
        checks++;
        if (grnt_ !== 4'b1011) begin errors++; $display("FAIL b2b_m2: got %b want 1011", grnt_); end
        req_ = 4'b0001;
        tick();
        checks++;
        if (grnt_ !== 4'b1011) begin errors++; $display("FAIL b2b_hold2: got %b want 1011", grnt_); end
        req_ = 4'b0101;
        tick();
        checks++;
        if (grnt_ !== 4'b0111) begin errors++; $display("FAIL b2b_m3: got %b want 0111", grnt_); end
        req_ = 4'b1101;
        tick();
        checks++;
        if (grnt_ !== 4'b1101) begin errors++; $display("FAIL b2b_m1_again: got %b want 1101", grnt_); end
        req_ = 4'b1111;
        tick();
    endtask

    task automatic test_reset_mid();
        req_ = 4'b1011;
        tick();
        checks++;
        if (grnt_ !== 4'b1011) begin errors++; $display("FAIL rm_m2: got %b want 1011", grnt_); end
        reset = 1'b1;
        tick();
        checks++;
        if (grnt_ !== 4'b1111 || owner !== 2'd0 || bus_idle !== 1'b1) begin
            errors++;
            $display("FAIL rm_reset: grnt %b owner %0d idle %b want 1111 0 1", grnt_, owner, bus_idle);
        end
        reset = 1'b0;
        req_  = 4'b1010;
        tick();
        checks++;
        if (grnt_ !== 4'b1110) begin errors++; $display("FAIL rm_m0_first: got %b want 1110", grnt_); end
        req_ = 4'b1111;
        tick();
        tick();
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req_ = 4'b1101;
        tick();
        req_ = 4'b1001;
        // Grant edge clears the counter; four owned increments precede the revoke edge.
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (grnt_ !== 4'b1101 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold c%0d: grnt %b timeout %b want 1101 0", c, grnt_, timeout);
            end
            if (c != 4) tick();
        end
        tick();
        checks++;
        if (grnt_ !== 4'b1111 || timeout !== 1'b1 || timeout_id !== 2'd1) begin
            errors++;
            $display("FAIL to_revoke: grnt %b timeout %b id %0d want 1111 1 1", grnt_, timeout, timeout_id);
        end
        tick();
        checks++;
        if (grnt_ !== 4'b1011 || timeout !== 1'b0 || timeout_id !== 2'd1) begin
            errors++;
            $display("FAIL to_m2: grnt %b timeout %b id %0d want 1011 0 1", grnt_, timeout, timeout_id);
        end
        req_ = 4'b1101;
        tick();
        checks++;
        if (grnt_ !== 4'b1111) begin errors++; $display("FAIL to_masked: got %b want 1111", grnt_); end
        tick();
        checks++;
        if (grnt_ !== 4'b1111) begin errors++; $display("FAIL to_still_masked: got %b want 1111", grnt_); end
        req_ = 4'b1111;
        tick();
        req_ = 4'b1101;
        tick();
        checks++;
        if (grnt_ !== 4'b1101) begin errors++; $display("FAIL to_regrant: got %b want 1101", grnt_); end
        req_ = 4'b1111;
        tick();
    endtask
`else
    task automatic test_unbounded_hold();
        int bad;
        bad  = 0;
        req_ = 4'b1011;
        tick();
        for (int c = 0; c < 1000; c++) begin
            checks++;
            if (grnt_ !== 4'b1011 || timeout !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 5) $display("FAIL hold_long c%0d: grnt %b timeout %b want 1011 0", c, grnt_, timeout);
            end
            tick();
        end
        req_ = 4'b1111;
        tick();
        checks++;
        if (grnt_ !== 4'b1111 || bus_idle !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: grnt %b idle %b want 1111 1", grnt_, bus_idle);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        req_  = 4'b1111;
        test_reset();
        test_single();
        test_round_robin();
        test_handoff_order();
        test_back_to_back();
        test_reset_mid();
`ifdef BUS_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_unbounded_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
